control_sequencer: RTL

//   Hardware control unit that drives every control input of ALUSystem.

---
 rtl/cu_pkg.sv | 98 +++++++++
 rtl/cu_decoder.sv | 105 ++++++++++
 rtl/control_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared types and encodings for the ALUSystem control sequencer: FSM states,
// opcodes, ALU/register/mux encodings and the idle control vector.
package cu_pkg;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned RSEL_W = 2;

  typedef enum logic [1:0] {
    T0,
    T1,
    T2,
    HALT
  } state_e;

  localparam logic [OPC_W-1:0] OP_LDI  = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
  localparam logic [OPC_W-1:0] OP_INC  = 4'h5;
  localparam logic [OPC_W-1:0] OP_DEC  = 4'h6;
  localparam logic [OPC_W-1:0] OP_BRA  = 4'h7;
  localparam logic [OPC_W-1:0] OP_BEQ  = 4'h8;
  localparam logic [OPC_W-1:0] OP_ST   = 4'h9;
  localparam logic [OPC_W-1:0] OP_LD   = 4'hA;
  localparam logic [OPC_W-1:0] OP_LDAR = 4'hB;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

  localparam logic [3:0] ALU_A   = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_OR  = 4'b1000;

  localparam logic [1:0] FUN_CLR  = 2'b00;
  localparam logic [1:0] FUN_LOAD = 2'b01;
  localparam logic [1:0] FUN_DEC  = 2'b10;
  localparam logic [1:0] FUN_INC  = 2'b11;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IMM = 2'b10;

  localparam logic MUXC_A = 1'b0;

  localparam logic [1:0] ADDR_AR = 2'b00;
  localparam logic [1:0] ADDR_PC = 2'b10;

  localparam logic [2:0] ARF_EN_NONE = 3'b111;
  localparam logic [2:0] ARF_EN_PC   = 3'b110;
  localparam logic [2:0] ARF_EN_AR   = 3'b011;

  typedef struct packed {
    logic [1:0] rf_out_a_sel;
    logic [1:0] rf_out_b_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_out_c_sel;
    logic [1:0] arf_out_d_sel;
    logic [1:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_funsel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    rf_out_a_sel:  2'b00,
    rf_out_b_sel:  2'b00,
    rf_fun_sel:    FUN_CLR,
    rf_reg_sel:    4'hF,
    alu_fun_sel:   ALU_A,
    arf_out_c_sel: 2'b00,
    arf_out_d_sel: ADDR_AR,
    arf_fun_sel:   FUN_CLR,
    arf_reg_sel:   ARF_EN_NONE,
    ir_lh:         1'b0,
    ir_enable:     1'b0,
    ir_funsel:     2'b00,
    mem_wr:        1'b0,
    mem_cs:        1'b1,
    mux_a_sel:     MUX_ALU,
    mux_b_sel:     MUX_ALU,
    mux_c_sel:     MUXC_A
  };

  // Active-low one-cold enable for a single register file entry.
  function automatic logic [3:0] rf_enable(input logic [RSEL_W-1:0] r);
    return ~(4'b0001 << r);
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational decode of FSM state, instruction register and Z flag into the
// full ALUSystem control vector.
module cu_decoder
  import cu_pkg::*;
(
  input  state_e      state_i,
  input  logic        rst_i,
  input  logic [15:0] ir_i,
  input  logic        z_i,
  output ctrl_t       ctrl_o
);

  logic [OPC_W-1:0]  opc;
  logic [RSEL_W-1:0] rd;
  logic [RSEL_W-1:0] rs;

  assign opc = ir_i[15:12];
  assign rd  = ir_i[11:10];
  assign rs  = ir_i[9:8];

  always_comb begin
    ctrl_o = CTRL_IDLE;
    // Idle while reset is held so a mid-fetch reset cannot write anything.
    if (!rst_i) begin
      unique case (state_i)
        T0, T1: begin
          ctrl_o.mem_cs        = 1'b0;
          ctrl_o.mem_wr        = 1'b0;
          ctrl_o.arf_out_d_sel = ADDR_PC;
          ctrl_o.ir_enable     = 1'b1;
          ctrl_o.ir_lh         = (state_i == T1);
          ctrl_o.ir_funsel     = FUN_LOAD;
          ctrl_o.arf_reg_sel   = ARF_EN_PC;
          ctrl_o.arf_fun_sel   = FUN_INC;
        end
        T2: begin
          case (opc)
            OP_LDI: begin
              ctrl_o.mux_a_sel  = MUX_IMM;
              ctrl_o.rf_fun_sel = FUN_LOAD;
              ctrl_o.rf_reg_sel = rf_enable(rd);
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              ctrl_o.rf_out_a_sel = rd;
              ctrl_o.rf_out_b_sel = rs;
              ctrl_o.mux_c_sel    = MUXC_A;
              ctrl_o.mux_a_sel    = MUX_ALU;
              ctrl_o.rf_fun_sel   = FUN_LOAD;
              ctrl_o.rf_reg_sel   = rf_enable(rd);
              case (opc)
                OP_ADD:  ctrl_o.alu_fun_sel = ALU_ADD;
                OP_SUB:  ctrl_o.alu_fun_sel = ALU_SUB;
                OP_AND:  ctrl_o.alu_fun_sel = ALU_AND;
                default: ctrl_o.alu_fun_sel = ALU_OR;
              endcase
            end
            OP_INC: begin
              ctrl_o.rf_fun_sel = FUN_INC;
              ctrl_o.rf_reg_sel = rf_enable(rd);
            end
            OP_DEC: begin
              ctrl_o.rf_fun_sel = FUN_DEC;
              ctrl_o.rf_reg_sel = rf_enable(rd);
            end
            OP_BRA: begin
              ctrl_o.mux_b_sel   = MUX_IMM;
              ctrl_o.arf_fun_sel = FUN_LOAD;
              ctrl_o.arf_reg_sel = ARF_EN_PC;
            end
            OP_BEQ: begin
              if (z_i) begin
                ctrl_o.mux_b_sel   = MUX_IMM;
                ctrl_o.arf_fun_sel = FUN_LOAD;
                ctrl_o.arf_reg_sel = ARF_EN_PC;
              end
            end
            OP_ST: begin
              ctrl_o.rf_out_a_sel  = rd;
              ctrl_o.mux_c_sel     = MUXC_A;
              ctrl_o.alu_fun_sel   = ALU_A;
              ctrl_o.mem_cs        = 1'b0;
              ctrl_o.mem_wr        = 1'b1;
              ctrl_o.arf_out_d_sel = ADDR_AR;
            end
            OP_LD: begin
              ctrl_o.mem_cs        = 1'b0;
              ctrl_o.arf_out_d_sel = ADDR_AR;
              ctrl_o.mux_a_sel     = MUX_MEM;
              ctrl_o.rf_fun_sel    = FUN_LOAD;
              ctrl_o.rf_reg_sel    = rf_enable(rd);
            end
            OP_LDAR: begin
              ctrl_o.mux_b_sel   = MUX_IMM;
              ctrl_o.arf_fun_sel = FUN_LOAD;
              ctrl_o.arf_reg_sel = ARF_EN_AR;
            end
            default: ;
          endcase
        end
        HALT: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer driving every ALUSystem control input.
// Optional CU_INSTR_COUNT_EN adds the instr_count retired-instruction counter.
module control_sequencer
  import cu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [1:0]  RF_OutASel,
  output logic [1:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
`ifdef CU_INSTR_COUNT_EN
  output logic [15:0] instr_count,
`endif
  output logic        halted
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   unused_flags;

  assign unused_flags = ^ALUOutFlag[2:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      T0:   state_d = T1;
      T1:   state_d = T2;
      T2:   state_d = (IROut[15:12] == OP_HLT) ? HALT : T0;
      HALT: state_d = HALT;
    endcase
  end

  cu_decoder u_decoder (
    .state_i (state_q),
    .rst_i   (Reset),
    .ir_i    (IROut),
    .z_i     (ALUOutFlag[3]),
    .ctrl_o  (ctrl)
  );

  assign RF_OutASel  = ctrl.rf_out_a_sel;
  assign RF_OutBSel  = ctrl.rf_out_b_sel;
  assign RF_FunSel   = ctrl.rf_fun_sel;
  assign RF_RegSel   = ctrl.rf_reg_sel;
  assign ALU_FunSel  = ctrl.alu_fun_sel;
  assign ARF_OutCSel = ctrl.arf_out_c_sel;
  assign ARF_OutDSel = ctrl.arf_out_d_sel;
  assign ARF_FunSel  = ctrl.arf_fun_sel;
  assign ARF_RegSel  = ctrl.arf_reg_sel;
  assign IR_LH       = ctrl.ir_lh;
  assign IR_Enable   = ctrl.ir_enable;
  assign IR_Funsel   = ctrl.ir_funsel;
  assign Mem_WR      = ctrl.mem_wr;
  assign Mem_CS      = ctrl.mem_cs;
  assign MuxASel     = ctrl.mux_a_sel;
  assign MuxBSel     = ctrl.mux_b_sel;
  assign MuxCSel     = ctrl.mux_c_sel;
  assign halted      = (state_q == HALT);

`ifdef CU_INSTR_COUNT_EN
  logic [15:0] count_q, count_d;

  // Only T2->T0 retires an instruction; the HLT exit goes to HALT instead.
  always_comb begin
    count_d = count_q;
    if (state_q == T2 && state_d == T0) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
`endif

endmodule
